piso_sr_param: RTL

Parametrised parallel-in/serial-out shift register with a ready/valid handshake on both the parallel load side and the serial output side. It replaces the fixed 4-bit PISO with a configurable-width, selectable-bit-order serialiser that supports backpressure and gapless back-to-back frames. It sits between a word-wide producer and a bit-serial link or transmitter.

---
 rtl/piso_pkg.sv | 18 +
 rtl/piso_sr_param_frame_cnt.sv | 33 +++
 rtl/piso_sr_param.sv | 130 +++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared types and helpers for the piso_sr_param serialiser.
//   piso_state_t : frame FSM state (IDLE = no frame held, SHIFT = frame in progress)
//   clog2_f      : constant ceil(log2) used to size the bit counter
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/piso_sr_param_frame_cnt.sv
// piso_frame_cnt: bit-position counter for one serial frame.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, count returns to 0
//   clear : restart the frame at bit 0 (wins over en)
//   en    : advance to the next bit position
//   tc    : count is at the final bit of the frame (FL-1)
// Parameters: FL (frame length in bits), CNT_W (counter width, must hold FL-1).
module piso_frame_cnt
  import piso_pkg::*;
#(
  parameter int FL    = 8,
  parameter int CNT_W = clog2_f(FL)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(FL - 1));

endmodule

// File: rtl/piso_sr_param.sv
// piso_sr_param: parameterised parallel-in/serial-out shift register with
// ready/valid handshakes on both the parallel load side and the serial side.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   load_valid : producer offers a word on load_data
//   load_ready : word is accepted this cycle
//   load_data  : WIDTH-bit parallel word
//   ser_ready  : consumer takes the current serial bit
//   ser_valid  : ser_out carries a valid bit
//   ser_out    : current serial bit
//   ser_last   : current bit is the last bit of the frame
// Parameters: WIDTH (2..64), MSB_FIRST (1: load_data[WIDTH-1] first, 0: load_data[0] first).
// Build option: define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_sr_param
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             ser_last
);

`ifdef PISO_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CNT_W = clog2_f(WIDTH + 1);

  piso_state_t      state, state_next;
  logic [WIDTH-1:0] sr, sr_shifted;
  logic             head;
  logic             tc;
  logic             xfer, last_xfer, load_acc;

  assign xfer       = ser_valid && ser_ready;
  assign last_xfer  = xfer && ser_last;
  // Combinational from ser_ready so the next word lands in the same cycle
  // the previous frame's last bit leaves: gapless back-to-back frames.
  assign load_ready = !rst && ((state == IDLE) || last_xfer);
  assign load_acc   = load_valid && load_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_acc) state_next = SHIFT;
      SHIFT:   if (last_xfer) state_next = load_acc ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift register: head bit sits at the end selected by MSB_FIRST
  always_comb begin
    if (MSB_FIRST != 0) begin
      head       = sr[WIDTH-1];
      sr_shifted = {sr[WIDTH-2:0], 1'b0};
    end else begin
      head       = sr[0];
      sr_shifted = {1'b0, sr[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load_acc) begin
      sr <= load_data;
    end else if (xfer && !ser_last) begin
      sr <= sr_shifted;
    end
  end

  // Counter restarts on every load and returns to 0 when a frame ends.
  piso_frame_cnt #(
    .FL    (FL),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (load_acc || last_xfer),
    .en    (xfer && !ser_last),
    .tc    (tc)
  );

`ifdef PISO_PARITY_EN
  logic parity;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (load_acc) begin
      parity <= ^load_data;
    end
  end

  // With parity the terminal count is exactly the parity slot.
  always_comb begin
    ser_valid = (state == SHIFT);
    ser_last  = (state == SHIFT) && tc;
    ser_out   = 1'b0;
    if (state == SHIFT) ser_out = tc ? parity : head;
  end
`else
  // FSM outputs
  always_comb begin
    ser_valid = (state == SHIFT);
    ser_last  = (state == SHIFT) && tc;
    ser_out   = (state == SHIFT) && head;
  end
`endif

endmodule
